// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - program-load, run, redirect and instruction-stream bundle for instr_fetch
interface instr_fetch_if #(
  parameter int PC_W = 8
);
  logic            load_en;
  logic [PC_W-1:0] load_addr;
  logic [31:0]     load_data;
  logic            run;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            instr_ready;
  logic            instr_valid;
  logic [31:0]     instruction;
  logic [PC_W-1:0] instr_pc;
  logic            busy;
  logic            halted;

  // master is the fetch stage; slave is the loader/decode side
  modport master (
    input  load_en, load_addr, load_data, run,
    input  redirect_valid, redirect_pc, instr_ready,
    output instr_valid, instruction, instr_pc, busy, halted
  );

  modport slave (
    output load_en, load_addr, load_data, run,
    output redirect_valid, redirect_pc, instr_ready,
    input  instr_valid, instruction, instr_pc, busy, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with loadable imem, PC, redirect; optional halt via FETCH_HALT_EN
module instr_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef FETCH_HALT_EN
  , parameter logic [3:0]    HALT_OPCODE = 4'hF
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_fetch_if.master bus
);

  localparam int              DEPTH  = 1 << PC_W;
  localparam logic [PC_W-1:0] PC_ONE = 1;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1} state_t;
`endif

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [31:0]     instr_q, instr_nxt;
  logic [PC_W-1:0] ipc_q, ipc_nxt;
  logic            valid_q, valid_nxt;
  logic            mem_we;
  logic            do_fetch;
  logic            advance;
  logic [31:0]     fetch_word;

  logic [31:0]     imem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      imem[bus.load_addr] <= bus.load_data;
    end
  end

  // A load and run in the same IDLE cycle forwards the word so the first fetch sees it
  always_comb begin
    fetch_word = imem[pc];
    if (state == IDLE && bus.load_en && bus.load_addr == pc) begin
      fetch_word = bus.load_data;
    end
  end

  assign advance = !valid_q || bus.instr_ready;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_q;
    ipc_nxt   = ipc_q;
    valid_nxt = valid_q;
    mem_we    = 1'b0;
    do_fetch  = 1'b0;

    case (state)
      IDLE: begin
        mem_we = bus.load_en;
        if (bus.run) begin
          do_fetch  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (bus.redirect_valid) begin
          pc_nxt    = bus.redirect_pc;
          valid_nxt = 1'b0;
        end else if (advance) begin
          do_fetch = 1'b1;
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        if (bus.redirect_valid) begin
          pc_nxt    = bus.redirect_pc;
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end else if (valid_q && bus.instr_ready) begin
          valid_nxt = 1'b0;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (do_fetch) begin
      instr_nxt = fetch_word;
      ipc_nxt   = pc;
      valid_nxt = 1'b1;
      pc_nxt    = pc + PC_ONE;
`ifdef FETCH_HALT_EN
      // The halt word itself is still presented; HALT only stops further fetches
      if (fetch_word[3:0] == HALT_OPCODE) begin
        state_nxt = HALT;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr_q <= instr_nxt;
      ipc_q   <= ipc_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign bus.instr_valid = valid_q;
  assign bus.instruction = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.busy        = (state != IDLE);
`ifdef FETCH_HALT_EN
  assign bus.halted      = (state == HALT);
`else
  assign bus.halted      = 1'b0;
`endif

endmodule
